hv_sram_arbiter: RTL and testbench



---
 rtl/hv_sram_arbiter_if.sv | 27 ++
 rtl/hv_sram_arbiter.sv | 122 ++++++++++++
 tb/tb_hv_sram_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hv_sram_arbiter_if.sv
// Request/response/SRAM signal bundle of hv_sram_arbiter.
// The slave modport is the arbiter; the master modport is the requester and SRAM side.
interface hv_sram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 2000
);
    logic [NUM_REQ-1:0]        ReqValid_SI;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr_DI;
    logic [NUM_REQ-1:0]        ReqReady_SO;
    logic [NUM_REQ-1:0]        RspValid_SO;
    logic [NUM_REQ*DATA_W-1:0] RspData_DO;
    logic [NUM_REQ-1:0]        RspReady_SI;
    logic                      SramEn_SO;
    logic [ADDR_W-1:0]         SramAddr_DO;
    logic [DATA_W-1:0]         SramRdata_DI;

    modport master (
        output ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
        input  ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
    );

    modport slave (
        input  ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
        output ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
    );
endinterface

// File: rtl/hv_sram_arbiter.sv
// Round-robin read arbiter sharing one fixed-latency hypervector SRAM between NUM_REQ requesters.
// Define HV_SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).
module hv_sram_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 2000,
    parameter int READ_LATENCY = 1
) (
    input logic              Clk_CI,
    input logic              Reset_RI,
    hv_sram_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [READ_LATENCY-1:0]   r_pipe_vld;
    logic [ID_W-1:0]           r_pipe_id [READ_LATENCY];
    logic [NUM_REQ-1:0]        r_rsp_vld;
    logic [NUM_REQ*DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0]         r_sram_addr;
`ifdef HV_SRAM_ARB_FIXED_PRIO_EN
`else
    logic [ID_W-1:0]           r_ptr;
`endif

    logic [NUM_REQ-1:0] w_busy;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;
    logic               w_hit;
    logic [ADDR_W-1:0]  w_win_addr;
    logic               w_tail_vld;
    logic [ID_W-1:0]    w_tail_id;
    int                 w_rank;
    int                 w_best;

    assign w_tail_vld = r_pipe_vld[READ_LATENCY-1];
    assign w_tail_id  = r_pipe_id[READ_LATENCY-1];

    // Busy tracking: a requester is blocked while its read is in flight or its response is held.
    always_comb begin
        w_busy = r_rsp_vld;
        for (int s = 0; s < READ_LATENCY; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_busy[i] = w_busy[i] | (r_pipe_vld[s] & (r_pipe_id[s] == ID_W'(i)));
            end
        end
        w_elig = bus.ReqValid_SI & ~w_busy;
    end

    // Arbitration: lowest rank wins; rank 0 is the requester just after the pointer.
    always_comb begin
        w_best   = NUM_REQ;
        w_rank   = 0;
        w_hit    = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef HV_SRAM_ARB_FIXED_PRIO_EN
            w_rank = i;
`else
            w_rank = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
`endif
            w_hit    = w_elig[i] && (w_rank < w_best);
            w_winner = w_hit ? ID_W'(i) : w_winner;
            w_best   = w_hit ? w_rank : w_best;
        end
        w_any   = (w_best < NUM_REQ);
        w_grant = w_any ? (NUM_REQ'(1) << w_winner) : {NUM_REQ{1'b0}};
    end

    // Winner address mux; falls back to the held copy when nothing is granted.
    always_comb begin
        w_win_addr = r_sram_addr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_addr = w_grant[i] ? bus.ReqAddr_DI[i*ADDR_W +: ADDR_W] : w_win_addr;
        end
    end

    assign bus.ReqReady_SO = w_grant;
    assign bus.SramEn_SO   = w_any;
    assign bus.SramAddr_DO = w_win_addr;
    assign bus.RspValid_SO = r_rsp_vld;
    assign bus.RspData_DO  = r_rsp_data;

    // Latency pipeline, pointer, held address and per-requester response registers.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_pipe_vld  <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipe_id[s] <= '0;
            end
            r_rsp_vld   <= '0;
            r_rsp_data  <= '0;
            r_sram_addr <= '0;
`ifdef HV_SRAM_ARB_FIXED_PRIO_EN
`else
            r_ptr       <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            r_pipe_vld[0] <= w_any;
            r_pipe_id[0]  <= w_winner;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
            r_sram_addr <= w_win_addr;
`ifdef HV_SRAM_ARB_FIXED_PRIO_EN
`else
            r_ptr <= w_any ? w_winner : r_ptr;
`endif
            // Capture and consume never hit the same index: one outstanding read per requester.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_tail_vld && (w_tail_id == ID_W'(i))) begin
                    r_rsp_vld[i]                  <= 1'b1;
                    r_rsp_data[i*DATA_W +: DATA_W] <= bus.SramRdata_DI;
                end else begin
                    r_rsp_vld[i] <= r_rsp_vld[i] & ~bus.RspReady_SI[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_hv_sram_arbiter.sv
// Self-checking bench for hv_sram_arbiter: READ_LATENCY=1 instance driven by a vector table,
// READ_LATENCY=3 instance by a hand sequence, response rows checked through a scoreboard.
module tb_hv_sram_arbiter;
    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 2000;
    localparam int NROWS = 34;
    localparam logic [DW-1:0] JUNK = {(DW/AW){8'hEE}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hv_sram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    hv_sram_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    hv_sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_a (
        .Clk_CI(clk), .Reset_RI(rst), .bus(ifa)
    );
    hv_sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut_b (
        .Clk_CI(clk), .Reset_RI(rst), .bus(ifb)
    );

    function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
        return {(DW/AW){a}};
    endfunction

    // SRAM models: correct row only exactly READ_LATENCY cycles after the enable, junk otherwise.
    logic           mem_a_vld = 1'b0;
    logic [AW-1:0]  mem_a_addr = '0;
    logic [2:0]     mem_b_vld = 3'b000;
    logic [AW-1:0]  mem_b_addr [3];
    always @(posedge clk) begin
        mem_a_vld     <= ifa.SramEn_SO;
        mem_a_addr    <= ifa.SramAddr_DO;
        mem_b_vld     <= {mem_b_vld[1:0], ifb.SramEn_SO};
        mem_b_addr[0] <= ifb.SramAddr_DO;
        mem_b_addr[1] <= mem_b_addr[0];
        mem_b_addr[2] <= mem_b_addr[1];
    end
    assign ifa.SramRdata_DI = mem_a_vld ? row_of(mem_a_addr) : JUNK;
    assign ifb.SramRdata_DI = mem_b_vld[2] ? row_of(mem_b_addr[2]) : JUNK;

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] rdy;
        logic [N-1:0] gnt;
        logic [N-1:0] rspv;
    } vec_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
    } sb_t;

    vec_t          tbl [NROWS];
    sb_t           sb_a [$];
    sb_t           sb_b [$];
    logic [AW-1:0] exp_addr [2];
    logic [N-1:0]  prev_v [2];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low word %08h, expected low word %08h", name, act[31:0], exp[31:0]);
        end
    endtask

    // One cycle: drive at posedge+1, check at the negedge, then advance to the next posedge+1.
    task automatic step(input int which, input string tag, input logic [N-1:0] req,
                        input logic [N-1:0] rdy, input logic [N*AW-1:0] addr,
                        input logic [N-1:0] eg, input logic [N-1:0] ev, input bit push);
        logic [N-1:0]    gnt;
        logic [N-1:0]    rv;
        logic [N-1:0]    rise;
        logic            en;
        logic [AW-1:0]   sa;
        logic [N*DW-1:0] rd;
        sb_t             e;
        bit              got;
        if (which == 0) begin
            ifa.ReqValid_SI = req; ifa.RspReady_SI = rdy; ifa.ReqAddr_DI = addr;
        end else begin
            ifb.ReqValid_SI = req; ifb.RspReady_SI = rdy; ifb.ReqAddr_DI = addr;
        end
        @(negedge clk);
        if (which == 0) begin
            gnt = ifa.ReqReady_SO; en = ifa.SramEn_SO; sa = ifa.SramAddr_DO;
            rv = ifa.RspValid_SO; rd = ifa.RspData_DO;
        end else begin
            gnt = ifb.ReqReady_SO; en = ifb.SramEn_SO; sa = ifb.SramAddr_DO;
            rv = ifb.RspValid_SO; rd = ifb.RspData_DO;
        end
        for (int i = 0; i < N; i++) begin
            if (eg[i]) exp_addr[which] = addr[i*AW +: AW];
        end
        chk({tag, " grant"}, 32'(gnt), 32'(eg));
        chk({tag, " sram_en"}, 32'(en), 32'(|eg));
        chk({tag, " sram_addr"}, 32'(sa), 32'(exp_addr[which]));
        chk({tag, " rsp_valid"}, 32'(rv), 32'(ev));
        rise = rv & ~prev_v[which];
        prev_v[which] = rv;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                got = 1'b0;
                e   = '0;
                if (which == 0) begin
                    if (sb_a.size() > 0) begin e = sb_a.pop_front(); got = 1'b1; end
                end else begin
                    if (sb_b.size() > 0) begin e = sb_b.pop_front(); got = 1'b1; end
                end
                if (got) begin
                    chk({tag, " rsp_id"}, 32'(i), 32'(e.id));
                    chk_row({tag, " rsp_data"}, rd[i*DW +: DW], row_of(e.addr));
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s unexpected_rsp: requester %0d rose, expected none", tag, i);
                end
            end
        end
        if (push) begin
            for (int i = 0; i < N; i++) begin
                if (eg[i]) begin
                    e.id   = 2'(i);
                    e.addr = addr[i*AW +: AW];
                    if (which == 0) sb_a.push_back(e);
                    else sb_b.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*AW-1:0] addr;
        ifa.ReqValid_SI = '0; ifa.RspReady_SI = '0; ifa.ReqAddr_DI = '0;
        ifb.ReqValid_SI = '0; ifb.RspReady_SI = '0; ifb.ReqAddr_DI = '0;
        exp_addr[0] = '0; exp_addr[1] = '0;
        prev_v[0]   = '0; prev_v[1]   = '0;

        // {req, rsp_ready, expected grant, expected rsp_valid}, READ_LATENCY=1, pointer starts at 2.
        tbl[0]  = '{3'b001, 3'b000, 3'b001, 3'b000};
        tbl[1]  = '{3'b000, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{3'b000, 3'b001, 3'b000, 3'b001};
        tbl[3]  = '{3'b000, 3'b000, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, 3'b111, 3'b010, 3'b000};
        tbl[5]  = '{3'b111, 3'b111, 3'b100, 3'b000};
        tbl[6]  = '{3'b111, 3'b111, 3'b001, 3'b010};
        tbl[7]  = '{3'b111, 3'b111, 3'b010, 3'b100};
        tbl[8]  = '{3'b111, 3'b111, 3'b100, 3'b001};
        tbl[9]  = '{3'b111, 3'b111, 3'b001, 3'b010};
        tbl[10] = '{3'b111, 3'b111, 3'b010, 3'b100};
        tbl[11] = '{3'b111, 3'b101, 3'b100, 3'b001};
        tbl[12] = '{3'b111, 3'b101, 3'b001, 3'b010};
        tbl[13] = '{3'b111, 3'b101, 3'b000, 3'b110};
        tbl[14] = '{3'b111, 3'b101, 3'b100, 3'b011};
        tbl[15] = '{3'b111, 3'b101, 3'b001, 3'b010};
        tbl[16] = '{3'b111, 3'b111, 3'b000, 3'b110};
        tbl[17] = '{3'b111, 3'b101, 3'b010, 3'b001};
        tbl[18] = '{3'b000, 3'b111, 3'b000, 3'b000};
        tbl[19] = '{3'b000, 3'b000, 3'b000, 3'b010};
        for (int k = 20; k < 30; k++) tbl[k] = '{3'b000, 3'b101, 3'b000, 3'b010};
        tbl[30] = '{3'b111, 3'b000, 3'b100, 3'b010};
        tbl[31] = '{3'b000, 3'b010, 3'b000, 3'b010};
        tbl[32] = '{3'b000, 3'b100, 3'b000, 3'b100};
        tbl[33] = '{3'b000, 3'b000, 3'b000, 3'b000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset grant", 32'(ifa.ReqReady_SO), 32'(3'b000));
        chk("reset sram_en", 32'(ifa.SramEn_SO), 32'(1'b0));
        chk("reset sram_addr", 32'(ifa.SramAddr_DO), 32'(8'h00));
        chk("reset rsp_valid", 32'(ifa.RspValid_SO), 32'(3'b000));
        chk("reset rsp_valid_b", 32'(ifb.RspValid_SO), 32'(3'b000));
        for (int i = 0; i < N; i++) chk_row("reset rsp_data", ifa.RspData_DO[i*DW +: DW], '0);
        rst = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            addr = {AW'(r + 48), AW'(r + 32), AW'(r + 16)};
            step(0, $sformatf("row%0d", r), tbl[r].req, tbl[r].rdy, addr, tbl[r].gnt, tbl[r].rspv, 1'b1);
        end

        // Reset one cycle after a grant: the in-flight read must vanish and the pointer restart.
        addr = {AW'(8'h61), AW'(8'h62), AW'(8'h63)};
        step(0, "rst_pre", 3'b010, 3'b000, addr, 3'b010, 3'b000, 1'b0);
        rst = 1'b1;
        step(0, "rst_in", 3'b000, 3'b000, addr, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        exp_addr[0] = '0;
        exp_addr[1] = '0;
        step(0, "rst_post", 3'b000, 3'b000, addr, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < N; i++) chk_row("rst_post rsp_data", ifa.RspData_DO[i*DW +: DW], '0);
        step(0, "rst_gnt", 3'b111, 3'b111, addr, 3'b001, 3'b000, 1'b1);
        step(0, "rst_d1", 3'b000, 3'b111, addr, 3'b000, 3'b000, 1'b0);
        step(0, "rst_d2", 3'b000, 3'b111, addr, 3'b000, 3'b001, 1'b0);
        step(0, "rst_d3", 3'b000, 3'b000, addr, 3'b000, 3'b000, 1'b0);

        // READ_LATENCY=3: back-to-back grants, each response valid exactly 4 cycles after grant.
        addr = {AW'(30), AW'(20), AW'(10)};
        step(1, "lat3_c0", 3'b001, 3'b111, addr, 3'b001, 3'b000, 1'b1);
        step(1, "lat3_c1", 3'b010, 3'b111, addr, 3'b010, 3'b000, 1'b1);
        step(1, "lat3_c2", 3'b100, 3'b111, addr, 3'b100, 3'b000, 1'b1);
        step(1, "lat3_c3", 3'b000, 3'b111, addr, 3'b000, 3'b000, 1'b0);
        step(1, "lat3_c4", 3'b000, 3'b111, addr, 3'b000, 3'b001, 1'b0);
        step(1, "lat3_c5", 3'b000, 3'b111, addr, 3'b000, 3'b010, 1'b0);
        step(1, "lat3_c6", 3'b000, 3'b111, addr, 3'b000, 3'b100, 1'b0);
        step(1, "lat3_c7", 3'b000, 3'b111, addr, 3'b000, 3'b000, 1'b0);
        step(1, "lat3_c8", 3'b000, 3'b000, addr, 3'b000, 3'b000, 1'b0);

        chk("scoreboard_a drained", 32'(sb_a.size()), 32'(0));
        chk("scoreboard_b drained", 32'(sb_b.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
